imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate extender for the decode->execute path.
//  - Takes an IN_W-bit immediate and a 2-bit mode; produces an OUT_W-bit operand
//    registered one cycle later.
//  - Modes: zero-extend, sign-extend, upper-placement (LUI) and branch offset
//    (sign-extend then shift left 2).
//  - Valid/ready handshake on both sides, 2-entry skid buffer so a stalled
//    consumer loses no data.
// PARAMETERS
//  IN_W   16  immediate width
//  OUT_W  32  result width; elaboration error if OUT_W < IN_W+2
// PORTS
//  CLK        in   1      clock, all state updates on posedge
//  Reset      in   1      synchronous, active-high
//  in_valid   in   1      producer offers immediate/ExtSel this cycle
//  in_ready   out  1      block can accept this cycle
//  ExtSel     in   2      mode: 00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH
//  immediate  in   IN_W   raw immediate field
//  out_valid  out  1      Extendout holds a valid result
//  out_ready  in   1      consumer takes the result this cycle
//  Extendout  out  OUT_W  extended result
// BEHAVIOUR
//  - Clock/reset: one clock CLK; Reset is synchronous, active-high.
//  - Reset values: out_valid=0, Extendout=0, skid empty. in_ready=0 while Reset is high, 1 on the first cycle after.
//  - Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
//  - Result function f, ALL arithmetic in OUT_W bits:
//    - ZERO: {0, imm}
//    - SIGN: {OUT_W-IN_W{imm[IN_W-1]}, imm}
//    - UPPER: imm << (OUT_W-IN_W), low bits 0
//    - BRANCH: SIGN(imm) << 2, top 2 bits discarded, bits [1:0]=0
//  - Latency: result of an accepted input visible on Extendout/out_valid the next cycle when the output register is free.
//  - in_ready = !skid_valid && !Reset. This is a registered-state decode; there is no combinational path from out_ready.
//  - Per cycle, in priority order:
//    a) skid_valid && transfer: main<=skid, skid_valid<=0.
//    b) !skid_valid && accept && (!out_valid || out_ready): main<=f(in), out_valid<=1.
//    c) !skid_valid && accept && out_valid && !out_ready: skid<=f(in), skid_valid<=1.
//    d) !skid_valid && !accept && transfer: out_valid<=0.
//    e) otherwise hold.
//  - Stall: Extendout and out_valid stable while out_valid && !out_ready.
//  - Ordering: strict FIFO. Throughput 1 result/cycle with out_ready=1.
//  - ExtSel/immediate are sampled only on accept. Changes while not accepted have no effect.
//  - Reset mid-operation (skid full or not): both entries dropped, outputs return to reset values next cycle. No partial result emitted.
//  - Extendout keeps its last value when out_valid=0. Checkers must ignore it then.
// STRUCTURE
//  - ext_pkg:
//    - localparams EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11
//    - function-free width-check constant
//  - Sub-module ext_core:
//    - purely combinational f(ExtSel, immediate), parametrised IN_W/OUT_W
//    - reused by the decoder for the unregistered path
//  - Top level holds the main register, the skid register and the handshake logic only.
// TESTING
//  1. IN_W=16/OUT_W=32: 0x8001 SIGN -> 0xFFFF8001; 0x8001 ZERO -> 0x00008001. Each appears exactly 1 cycle after accept.
//  2. UPPER 0x1234 -> 0x12340000; BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x7FFF -> 0x0001FFFC.
//  3. out_ready=0, push A then B: B lands in skid, in_ready=0 next cycle, C held by producer.
//     Raise out_ready -> A, B, C delivered in order with no loss or duplicate.
//  4. in_valid=1, out_ready=1 for 100 random items: one result/cycle, in_ready never drops, all match the model.
//  5. Skid full, assert Reset 1 cycle: next cycle out_valid=0, Extendout=0; first cycle after deassert in_ready=1, old A/B never emitted.
//  6. IN_W=8/OUT_W=16: SIGN 0x80 -> 0xFF80; UPPER 0xAB -> 0xAB00; BRANCH 0xC0 -> 0xFF00.
//     IN_W=16/OUT_W=17 fails elaboration.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate extender.
// EXT_MARGIN is the headroom the branch shift needs above IN_W.
package ext_pkg;
    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;
    localparam int         EXT_MARGIN = 2;
endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension f(ext_sel, imm).
// Shared by the pipelined extender and the unregistered decode path.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [1:0]       ext_sel,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext_out
);
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    assign zext   = {{(OUT_W-IN_W){1'b0}}, imm};
    assign sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign upper  = {imm, {(OUT_W-IN_W){1'b0}}};
    assign branch = sext << 2;

    always_comb begin
        ext_out = zext;
        unique case (ext_sel)
            EXT_ZERO:   ext_out = zext;
            EXT_SIGN:   ext_out = sext;
            EXT_UPPER:  ext_out = upper;
            EXT_BRANCH: ext_out = branch;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready on both sides.
// A one-entry skid behind the output register absorbs a consumer stall.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ExtSel,
    input  logic [IN_W-1:0]  immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] Extendout
);
    if (OUT_W < IN_W + EXT_MARGIN) begin : g_width_err
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             accept;
    logic             transfer;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .ext_sel (ExtSel),
        .imm     (immediate),
        .ext_out (ext_val)
    );

    // in_ready depends only on state and reset, never on out_ready
    assign in_ready  = !skid_valid_q && !Reset;
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign Extendout = main_q;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (transfer) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                main_d      = ext_val;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = ext_val;
                skid_valid_d = 1'b1;
            end
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, scoreboard,
// skid/stall, streaming, reset-flush and an 8/16 width instance.
module tb_imm_extend_pipe;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ExtSel = 2'b00;
    logic [15:0] immediate = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Extendout;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [1:0]  sel8 = 2'b00;
    logic [7:0]  imm8 = '0;
    logic        out_valid8;
    logic [15:0] ext8;

    int passed = 0;
    int total  = 0;
    int delivered = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ExtSel    (ExtSel),
        .immediate (immediate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Extendout (Extendout)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .ExtSel    (sel8),
        .immediate (imm8),
        .out_valid (out_valid8),
        .out_ready (1'b1),
        .Extendout (ext8)
    );

    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] v);
        logic [31:0] s;
        s = $unsigned(32'($signed(v)));
        case (m)
            2'b00:   return {16'h0000, v};
            2'b01:   return s;
            2'b10:   return {v, 16'h0000};
            default: return s * 32'd4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: pop on transfer, push on accept, flush on reset
    always @(negedge CLK) begin
        if (Reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got %h expected none", Extendout);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (Extendout === e) passed++;
                    else $display("FAIL sb_data: got %h expected %h", Extendout, e);
                end
                delivered++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(ExtSel, immediate));
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  imm;
        logic [15:0] exp;
    } vec8_t;

    vec_t  tbl[6];
    vec8_t tbl8[3];

    initial begin
        tbl[0] = '{2'b01, 16'h8001, 32'hFFFF8001};
        tbl[1] = '{2'b00, 16'h8001, 32'h00008001};
        tbl[2] = '{2'b10, 16'h1234, 32'h12340000};
        tbl[3] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
        tbl[4] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
        tbl[5] = '{2'b01, 16'h7ABC, 32'h00007ABC};
        tbl8[0] = '{2'b01, 8'h80, 16'hFF80};
        tbl8[1] = '{2'b10, 8'hAB, 16'hAB00};
        tbl8[2] = '{2'b11, 8'hC0, 16'hFF00};

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_extendout", Extendout, 32'h0);
        Reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table, one cycle latency each
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            ExtSel    = tbl[i].sel;
            immediate = tbl[i].imm;
            tick();
            in_valid  = 1'b0;
            ExtSel    = ~tbl[i].sel;
            immediate = ~tbl[i].imm;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), Extendout, tbl[i].exp);
            tick();
        end
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Stall: A to main, B to skid, C held by producer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ExtSel    = 2'b01;
        immediate = 16'hA000;
        tick();
        immediate = 16'h0B0B;
        ExtSel    = 2'b11;
        tick();
        check("skid_in_ready", 32'(in_ready), 32'd0);
        ExtSel    = 2'b10;
        immediate = 16'h00CC;
        tick();
        tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", Extendout, 32'hFFFFA000);
        out_ready = 1'b1;
        delivered = 0;
        tick();
        check("skid_to_main", Extendout, 32'h0002C2C);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abc_delivered", 32'(delivered), 32'd3);

        // Streaming 100 random items
        delivered = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ExtSel    = 2'($urandom_range(0, 3));
            immediate = 16'($urandom);
            #1;
            check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_delivered", 32'(delivered), 32'd100);

        // Reset with skid full drops both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ExtSel    = 2'b00;
        immediate = 16'h1111;
        tick();
        immediate = 16'h2222;
        tick();
        in_valid = 1'b0;
        check("pre_rst_skid_full", 32'(in_ready), 32'd0);
        Reset = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_extendout", Extendout, 32'h0);
        Reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        delivered = 0;
        for (int i = 0; i < 4; i++) tick();
        check("midrst_no_emit", 32'(delivered), 32'd0);

        // Narrow instance
        for (int i = 0; i < 3; i++) begin
            in_valid8 = 1'b1;
            sel8      = tbl8[i].sel;
            imm8      = tbl8[i].imm;
            tick();
            in_valid8 = 1'b0;
            check($sformatf("w8_vec%0d_valid", i), 32'(out_valid8), 32'd1);
            check($sformatf("w8_vec%0d_data", i), 32'(ext8), 32'(tbl8[i].exp));
            tick();
        end

        // Bounded drain of the scoreboard
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
